// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the framed-FIFO reader: FSM states, output beat payload, buffer depth.
package frame_reader_pkg;

  localparam int unsigned FR_BUF_DEPTH  = 2;
  localparam int unsigned FR_DATA_W_MAX = 32;
  localparam int unsigned FR_LEN_W_MAX  = 32;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } fr_state_e;

  // Sized for the widest supported configuration; narrower instances zero-extend.
  typedef struct packed {
    logic [FR_DATA_W_MAX-1:0] data;
    logic                     sof;
    logic                     eof;
    logic                     err;
    logic [FR_LEN_W_MAX-1:0]  len;
  } fr_beat_t;

endpackage

// File: rtl/frame_reader_obuf.sv
// Two-entry output buffer with valid/ready on both sides; the head entry drives the output directly.
module frame_reader_obuf
  import frame_reader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  fr_beat_t   in_beat_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output fr_beat_t   out_beat_o,
  output logic [1:0] count_o
);

  localparam int unsigned CNT_W = 2;

  fr_beat_t           head_q, head_d;
  fr_beat_t           tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_c;
  logic               pop_c;

  assign out_valid_o = (count_q != '0);
  assign in_ready_o  = (count_q < CNT_W'(FR_BUF_DEPTH)) || out_ready_i;
  assign push_c      = in_valid_i && in_ready_o;
  assign pop_c       = out_valid_o && out_ready_i;
  assign out_beat_o  = head_q;
  assign count_o     = count_q;

  // Head always holds the oldest entry so the output only changes on a pop or when empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (pop_c && (count_q == CNT_W'(FR_BUF_DEPTH))) begin
      head_d = tail_q;
    end
    if (push_c) begin
      if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_c)) begin
        head_d = in_beat_i;
      end else begin
        tail_d = in_beat_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Pops a framed FIFO, enforces sof/eof framing, drops orphan bytes and streams beats with frame length.
// Optional statistics outputs (frame_cnt, err_cnt) are built when FRAME_READER_STATS_EN is defined.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  rd_en,
  input  logic                  rd_sof,
  input  logic                  rd_eof,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_err,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  drop_pulse
`ifdef FRAME_READER_STATS_EN
  ,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           err_cnt
`endif
);

  localparam int unsigned LVL_W = 3;

  fr_state_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   len_inc_c;
  logic                   inflight_q;
  logic                   drop_q, drop_d;
  logic                   fwd_c;
  logic                   push_c;
  logic                   pop_c;
  logic [LVL_W-1:0]       level_c;
  fr_beat_t               beat_c;
  fr_beat_t               obuf_beat;
  logic                   obuf_in_ready;
  logic [1:0]             obuf_count;
  logic                   unused_hi_c;

  // Occupancy after this cycle's pop plus the byte already requested must leave a free slot.
  assign pop_c   = out_valid && out_ready;
  assign level_c = LVL_W'(obuf_count) + LVL_W'(inflight_q) - LVL_W'(pop_c);
  assign rd_en   = !reset && !empty && (level_c < LVL_W'(FR_BUF_DEPTH));

  assign len_inc_c = (len_q == '1) ? len_q : len_q + LEN_WIDTH'(1);
  assign push_c    = fwd_c && obuf_in_ready;

  // Framing FSM: classifies the byte returned for last cycle's pop.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fwd_c   = 1'b0;
    drop_d  = 1'b0;
    beat_c  = '0;
    if (inflight_q) begin
      if (rd_sof) begin
        fwd_c   = 1'b1;
        len_d   = LEN_WIDTH'(1);
        state_d = rd_eof ? IDLE : IN_FRAME;
      end else if (state_q == IN_FRAME) begin
        fwd_c   = 1'b1;
        len_d   = len_inc_c;
        state_d = rd_eof ? IDLE : IN_FRAME;
      end else begin
        drop_d  = 1'b1;
      end
      beat_c.data = FR_DATA_W_MAX'(dout);
      beat_c.sof  = rd_sof;
      beat_c.eof  = rd_eof;
      beat_c.err  = rd_sof && (state_q == IN_FRAME);
      beat_c.len  = FR_LEN_W_MAX'(len_d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      inflight_q <= rd_en;
      drop_q     <= drop_d;
    end
  end

  frame_reader_obuf u_obuf (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (push_c),
    .in_ready_o  (obuf_in_ready),
    .in_beat_i   (beat_c),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_beat_o  (obuf_beat),
    .count_o     (obuf_count)
  );

  assign out_data    = DATA_WIDTH'(obuf_beat.data);
  assign out_sof     = obuf_beat.sof;
  assign out_eof     = obuf_beat.eof;
  assign out_err     = obuf_beat.err;
  assign out_len     = LEN_WIDTH'(obuf_beat.len);
  assign drop_pulse  = drop_q;
  assign unused_hi_c = ^{obuf_beat.data >> DATA_WIDTH, obuf_beat.len >> LEN_WIDTH};

`ifdef FRAME_READER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [31:0] err_cnt_q;

  // Protocol errors are counted both as flagged beats leaving and as dropped orphans.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 32'(pop_c && out_eof);
      err_cnt_q   <= err_cnt_q + 32'(pop_c && out_err) + 32'(drop_q);
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: behavioural framed FIFO in front, expected-beat queue behind.
module tb_frame_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } fifo_ent_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic [15:0] len;
  } exp_beat_t;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic        rd_sof;
  logic        rd_eof;
  logic [7:0]  dout;
  logic        empty;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] out_len;
  logic        drop_pulse;
`ifdef FRAME_READER_STATS_EN
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
`endif

  frame_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_sof     (rd_sof),
    .rd_eof     (rd_eof),
    .dout       (dout),
    .empty      (empty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_err    (out_err),
    .out_len    (out_len),
    .drop_pulse (drop_pulse)
`ifdef FRAME_READER_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fifo_ent_t   fifo[$];
  exp_beat_t   exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          drop_cnt = 0;
  int          first_rd, first_vld, first_x, last_x, n_xfer;
  logic        pop_pend = 1'b0;
  logic        hold_v = 1'b0;
  logic [26:0] hold_vec;
  logic [3:0]  rdy_pat = 4'b1111;
  int          rdy_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic s, input logic e);
    fifo_ent_t ent;
    ent.data = d; ent.sof = s; ent.eof = e;
    fifo.push_back(ent);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic s, input logic e,
                             input logic r, input logic [15:0] l);
    exp_beat_t b;
    b.data = d; b.sof = s; b.eof = e; b.err = r; b.len = l;
    exp_q.push_back(b);
  endtask

  // One clock: drive FIFO/ready after the edge, sample DUT at the falling edge.
  task automatic step();
    fifo_ent_t ent;
    exp_beat_t e;
    logic [26:0] cur;
    @(posedge clock);
    #1;
    if (pop_pend) begin
      chk("pop_data_available", 64'(fifo.size() != 0), 64'(1));
      if (fifo.size() != 0) begin
        ent = fifo.pop_front();
        dout = ent.data; rd_sof = ent.sof; rd_eof = ent.eof;
      end
    end else begin
      dout = 8'($urandom); rd_sof = 1'($urandom); rd_eof = 1'($urandom);
    end
    empty = (fifo.size() == 0);
    out_ready = rdy_pat[rdy_idx];
    rdy_idx = (rdy_idx + 1) % 4;
    @(negedge clock);
    cyc++;
    pop_pend = rd_en;
    if (rd_en) begin
      chk("rd_en_vs_empty", 64'(empty), 64'(0));
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid && first_vld < 0) first_vld = cyc;
    cur = {out_data, out_sof, out_eof, out_err, out_len};
    if (hold_v) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_beat", 64'(cur), 64'(hold_vec));
    end
    hold_v = out_valid && !out_ready;
    hold_vec = cur;
    if (out_valid && out_ready) begin
      n_xfer++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", 64'(out_data), 64'(e.data));
        chk("beat_flags", 64'({out_sof, out_eof, out_err}), 64'({e.sof, e.eof, e.err}));
        if (e.eof) chk("beat_len", 64'(out_len), 64'(e.len));
      end
    end
    if (drop_pulse) drop_cnt++;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    hold_v = 1'b0;
    #1;
    pop_pend = rd_en;
  endtask

  task automatic begin_test();
    first_rd = -1; first_vld = -1; first_x = -1; last_x = -1; n_xfer = 0;
    rdy_idx = 0;
  endtask

  task automatic drain(input string tag, input int drops_exp);
    int d0;
    bit done;
    d0 = drop_cnt;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      done = (fifo.size() == 0) && !pop_pend && (exp_q.size() == 0) && !out_valid;
    end
    if (!done) chk({tag, "_drain_timeout"}, 64'(exp_q.size() + fifo.size()), 64'(0));
    repeat (3) step();
    chk({tag, "_drops"}, 64'(drop_cnt - d0), 64'(drops_exp));
  endtask

  logic [29:0] rst_vec;
  assign rst_vec = {rd_en, out_valid, out_sof, out_eof, out_err, drop_pulse, out_data, out_len};

  initial begin
    reset = 1'b1; empty = 1'b1; out_ready = 1'b0;
    dout = '0; rd_sof = 1'b0; rd_eof = 1'b0;
    begin_test();
    repeat (3) step();
    chk("reset_outputs", 64'(rst_vec), 64'(0));
    set_reset(1'b0);

    // Three-byte frame and first-beat latency
    begin_test(); rdy_pat = 4'b1111;
    push_byte(8'hA1, 1, 0); push_byte(8'hA2, 0, 0); push_byte(8'hA3, 0, 1);
    expect_beat(8'hA1, 1, 0, 0, 16'd0); expect_beat(8'hA2, 0, 0, 0, 16'd0);
    expect_beat(8'hA3, 0, 1, 0, 16'd3);
    drain("t1", 0);
    chk("t1_latency", 64'(first_vld - first_rd), 64'(2));

    // Single-byte frame
    begin_test();
    push_byte(8'h55, 1, 1);
    expect_beat(8'h55, 1, 1, 0, 16'd1);
    drain("t2", 0);
    chk("t2_beats", 64'(n_xfer), 64'(1));

    // Orphans dropped in IDLE
    begin_test();
    push_byte(8'h10, 0, 0); push_byte(8'h11, 0, 0);
    push_byte(8'h20, 1, 0); push_byte(8'h21, 0, 1);
    expect_beat(8'h20, 1, 0, 0, 16'd0); expect_beat(8'h21, 0, 1, 0, 16'd2);
    drain("t3", 2);
    chk("t3_beats", 64'(n_xfer), 64'(2));

    // Missing eof: new sof restarts the frame with err
    begin_test();
    push_byte(8'h30, 1, 0); push_byte(8'h31, 0, 0);
    push_byte(8'h40, 1, 0); push_byte(8'h41, 0, 1);
    expect_beat(8'h30, 1, 0, 0, 16'd0); expect_beat(8'h31, 0, 0, 0, 16'd0);
    expect_beat(8'h40, 1, 0, 1, 16'd0); expect_beat(8'h41, 0, 1, 0, 16'd2);
    drain("t4", 0);

    // Ten-byte frame under back-pressure 1,0,0,1
    begin_test(); rdy_pat = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'(8'hB0 + i), i == 0, i == 9);
      expect_beat(8'(8'hB0 + i), i == 0, i == 9, 0, 16'd10);
    end
    drain("t5", 0);
    chk("t5_beats", 64'(n_xfer), 64'(10));

    // Throughput with ready held high
    begin_test(); rdy_pat = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'(8'hC0 + i), i == 0, i == 7);
      expect_beat(8'(8'hC0 + i), i == 0, i == 7, 0, 16'd8);
    end
    drain("t7", 0);
    chk("t7_beats", 64'(n_xfer), 64'(8));
    chk("t7_back_to_back", 64'(last_x - first_x), 64'(7));

`ifdef FRAME_READER_STATS_EN
    chk("stats_frame_cnt", 64'(frame_cnt), 64'(6));
    chk("stats_err_cnt", 64'(err_cnt), 64'(3));
`endif

    // Reset mid-frame with two bytes buffered
    begin_test(); rdy_pat = 4'b0000;
    push_byte(8'h50, 1, 0); push_byte(8'h51, 0, 0);
    repeat (6) step();
    chk("t6_buffered_valid", 64'(out_valid), 64'(1));
    set_reset(1'b1);
    repeat (2) step();
    chk("t6_reset_outputs", 64'(rst_vec), 64'(0));
    set_reset(1'b0);
    rdy_pat = 4'b1111;
    push_byte(8'h52, 0, 0); push_byte(8'h53, 0, 0); push_byte(8'h54, 0, 1);
    drain("t6", 3);
    chk("t6_beats", 64'(n_xfer), 64'(0));

`ifdef FRAME_READER_STATS_EN
    chk("stats_frame_cnt_post_rst", 64'(frame_cnt), 64'(0));
    chk("stats_err_cnt_post_rst", 64'(err_cnt), 64'(3));
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
